fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single write port of a FIFO among NREQ requesters.
//  The winner holds the port for a burst of up to BURST words, then rotates priority.
//  Sits in the write-clock domain directly in front of the FIFO: winc/wdata drive the FIFO, wfull is fed back.
// PARAMETERS
//  NREQ   4  number of requesters (>=2)
//  DSIZE  8  data width, equal to the FIFO DSIZE
//  BURST  4  max words per grant (>=1)
// PORTS
//  clk       in   1           write-domain clock, rising edge
//  rst       in   1           synchronous active-high reset
//  req       in   NREQ        req[i]: requester i has a word on its data slice
//  req_data  in   NREQ*DSIZE  slice i = req_data[i*DSIZE +: DSIZE]
//  gnt       out  NREQ        one-hot registered grant; all zero when idle
//  ack       out  NREQ        ack[i]: requester i's word is written this cycle
//  wfull     in   1           FIFO full flag
//  winc      out  1           FIFO write strobe
//  wdata     out  DSIZE       FIFO write data
//  owner     out  IW          index of granted requester, IW = max(1, clog2(NREQ))
//  busy      out  1           1 while in GRANT
// BEHAVIOUR
//  - Reset values (next clk edge with rst=1):
//    state=IDLE, gnt=0, owner=0, busy=0, burst count=0, last-winner pointer=NREQ-1.
//    With these, req[0] has top priority on the first arbitration.
//    winc=0 and ack=0 in the first post-reset cycle.
//  - FSM with two states, IDLE and GRANT.
//  - IDLE:
//    - If |req, pick the first set bit scanning from last+1 upward with wrap.
//    - Next edge: GRANT, gnt=onehot(pick), owner=pick, last=pick, count=0.
//    - Grant latency is one cycle from req to gnt.
//  - GRANT: a beat is defined as accept = req[owner] & ~wfull (combinational).
//    - winc = accept.
//    - wdata = req_data slice[owner], driven whenever in GRANT.
//    - ack[owner] = accept; every other ack bit is 0.
//    - A requester treats ack as "pop": it advances to its next word at the edge.
//  - Burst count and release:
//    - count increments on each accept.
//    - Release to IDLE when an accept occurs with count==BURST-1.
//    - Also release when req[owner]==0; no write occurs that cycle.
//    - On release: gnt=0 and count=0 next edge.
//    - One idle bubble cycle always separates grants. Rotation is guaranteed even if only one requester is active.
//  - wfull=1 in GRANT:
//    - winc=0 and count holds; the grant is kept, with no timeout.
//    - Writing resumes the cycle wfull falls.
//  - Count is only changed by beats; it wraps to 0 only via release.
//  - Non-owner req changes during GRANT have no effect until the next IDLE.
//  - rst in any state returns to IDLE on that edge. The in-flight burst is abandoned.
//    Words already acked stay in the FIFO, since the FIFO has its own reset.
//  - winc is never asserted while wfull=1, so no write is ever dropped.
// STRUCTURE
//  - Shared package/include holds:
//    - state localparams ST_IDLE=1'b0 and ST_GRANT=1'b1;
//    - a clog2 function for IW and the count width clog2(BURST+1).
//  - One sub-module: rr_pick (NREQ). It is combinational.
//    - Inputs: req and last pointer. Outputs: pick index and valid.
//    - It is reusable by the read-side scheduler.
//  - The top holds the FSM, the owner/last/count registers and the data mux.
// TESTING (NREQ=4, DSIZE=8, BURST=4)
//  1. req[1]=1 with words 0x10..0x15, wfull=0.
//     -> gnt=4'b0010 one cycle later, winc on 4 cycles writing 0x10..0x13.
//     -> 1 IDLE cycle, regrant, 0x14,0x15 written.
//     -> req drops, gnt=0.
//  2. req=4'b1111 held, each source sending its own stream.
//     -> grant order 0,1,2,3,0.
//     -> exactly 4 winc per grant, one bubble between grants.
//  3. Owner 2 mid-burst after 2 words; wfull=1 for 3 cycles.
//     -> winc=0 and ack=0 during the stall; gnt stays 4'b0100.
//     -> after wfull falls, exactly 2 more words, then release.
//  4. Owner 0 drops req after 1 word while req[3]=1.
//     -> release next edge; after the bubble, gnt=4'b1000 (req[3] wins, being first after last=0).
//  5. rst=1 for one cycle while in GRANT for owner 2 with count=2.
//     -> next cycle gnt=0, busy=0, winc=0.
//     -> with req=4'b0110, the next grant goes to requester 1 (last reset to 3, so scan starts at 0).
//  6. Scoreboard every run: FIFO contents equal the concatenation of acked words per requester, in order.
//     -> no winc while wfull=1 (assertion).

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_wr_arbiter_pkg
//   Shared definitions for the FIFO write-port arbiter and its helpers:
//   FSM state encodings and width helpers used to size index and counter
//   fields.
//   No ports (package).
package fifo_wr_arbiter_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // ceil(log2(value)); 0 for value <= 1
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Index width that never collapses to zero bits
  function automatic int idx_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if
//   Bundle of requester-side and FIFO-side write signals around the arbiter.
//   Signals:
//     req       requester i has a word on its data slice
//     req_data  slice i = req_data[i*DSIZE +: DSIZE]
//     gnt       one-hot registered grant, zero when idle
//     ack       requester i's word is written this cycle
//     wfull     FIFO full flag
//     winc      FIFO write strobe
//     wdata     FIFO write data
//     owner     index of the granted requester
//     busy      arbiter holds a grant
//   Modports:
//     slave   the arbiter
//     master  the requesters and FIFO around it
interface fifo_wr_arbiter_if
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8,
  parameter int IW    = idx_width(NREQ)
) ();

  logic [NREQ-1:0]       req;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic                  wfull;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic [IW-1:0]         owner;
  logic                  busy;

  modport slave (
    input  req, req_data, wfull,
    output gnt, ack, winc, wdata, owner, busy
  );

  modport master (
    output req, req_data, wfull,
    input  gnt, ack, winc, wdata, owner, busy
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin picker. Returns the first set request bit
//   scanning upward from last+1 with wrap-around. Shared with the read-side
//   scheduler, so it carries no FSM knowledge.
//   Ports:
//     req    in   NREQ  request vector
//     last   in   IW    index of the previous winner
//     pick   out  IW    winning index (0 when nothing is requested)
//     valid  out  1     at least one request is set
module rr_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [IW-1:0]   pick,
  output logic            valid
);

  logic [NREQ-1:0] upper;
  logic            hi_found;
  logic [IW-1:0]   hi_pick;
  logic [IW-1:0]   lo_pick;

  // Requests strictly above last win first; otherwise wrap to the lowest set bit.
  always_comb begin
    upper    = '0;
    hi_found = 1'b0;
    hi_pick  = '0;
    lo_pick  = '0;
    for (int i = 0; i < NREQ; i++) begin
      upper[i] = req[i] && (i > int'(last));
    end
    // descending scan so the lowest qualifying index is written last
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (upper[i]) begin
        hi_found = 1'b1;
        hi_pick  = IW'(i);
      end
      if (req[i]) begin
        lo_pick = IW'(i);
      end
    end
    pick  = hi_found ? hi_pick : lo_pick;
    valid = |req;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter sharing one FIFO write port among NREQ requesters.
//   The winner keeps the port for up to BURST written words, then an idle
//   bubble cycle forces re-arbitration so priority always rotates.
//   Ports:
//     clk   in   write-domain clock, rising edge
//     rst   in   synchronous active-high reset
//     bus   slave modport of fifo_wr_arbiter_if (requests, grant, FIFO write)
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no grant; arbitrate among req, grant lands on the next edge
//   ST_GRANT | owner drives the write port until burst end or req drop
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8,
  parameter int BURST = 4
) (
  input logic              clk,
  input logic              rst,
  fifo_wr_arbiter_if.slave bus
);

  localparam int IW = idx_width(NREQ);
  localparam int CW = clog2(BURST + 1);

  logic [0:0]       state_q;
  logic [NREQ-1:0]  gnt_q;
  logic [IW-1:0]    owner_q;
  logic [IW-1:0]    last_q;
  logic [CW-1:0]    cnt_q;

  logic [IW-1:0]    pick;
  logic             pick_valid;
  logic [NREQ-1:0]  pick_onehot;
  logic             in_grant;
  logic             owner_req;
  logic [DSIZE-1:0] owner_data;
  logic             accept;
  logic             last_beat;
  logic             release_now;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req   (bus.req),
    .last  (last_q),
    .pick  (pick),
    .valid (pick_valid)
  );

  assign in_grant = (state_q == ST_GRANT);

  always_comb begin
    owner_req   = 1'b0;
    owner_data  = '0;
    pick_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == IW'(i)) begin
        owner_req  = bus.req[i];
        owner_data = bus.req_data[i*DSIZE +: DSIZE];
      end
      pick_onehot[i] = (pick == IW'(i));
    end
  end

  // Gating on wfull here is what guarantees no write is ever dropped.
  assign accept      = in_grant && owner_req && !bus.wfull;
  assign last_beat   = (cnt_q == CW'(BURST - 1));
  // A dropped owner request releases without writing; a stall never releases.
  assign release_now = in_grant && ((accept && last_beat) || !owner_req);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      last_q  <= IW'(NREQ - 1);
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            state_q <= ST_GRANT;
            gnt_q   <= pick_onehot;
            owner_q <= pick;
            last_q  <= pick;
            cnt_q   <= '0;
          end
        end
        ST_GRANT: begin
          if (release_now) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            cnt_q   <= '0;
          end else if (accept) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.ack = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.ack[i] = accept && (owner_q == IW'(i));
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.winc  = accept;
  assign bus.wdata = in_grant ? owner_data : '0;
  assign bus.owner = owner_q;
  assign bus.busy  = in_grant;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
//   Directed bench for fifo_wr_arbiter (NREQ=4, DSIZE=8, BURST=4).
//   Requesters are modelled as word queues that pop on ack; a FIFO model
//   records every written word.
module tb_fifo_wr_arbiter;

  logic clk;
  logic rst;

  fifo_wr_arbiter_if #(.NREQ(4), .DSIZE(8)) bus ();

  fifo_wr_arbiter #(
    .NREQ  (4),
    .DSIZE (8),
    .BURST (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] en;
    logic       wf;
    logic       chk;
    logic [3:0] gnt;
    logic       winc;
    logic [7:0] wdata;
    logic       busy;
    logic [1:0] owner;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] src_q[4][$];
  logic [7:0] fifo_q[$];
  logic [7:0] acked_q[$];

  int n_checks = 0;
  int n_err    = 0;
  int viol     = 0;

  logic [3:0] s_gnt;
  logic [3:0] s_ack;
  logic       s_winc;
  logic [7:0] s_wdata;
  logic       s_busy;
  logic [1:0] s_owner;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [3:0] en, input logic wf,
                              input logic c, input logic [3:0] g, input logic w,
                              input logic [7:0] d, input logic b, input logic [1:0] o);
    vec_t v;
    v.rst = r; v.en = en; v.wf = wf; v.chk = c;
    v.gnt = g; v.winc = w; v.wdata = d; v.busy = b; v.owner = o;
    return v;
  endfunction

  task automatic load(input int i, input logic [7:0] first, input int n);
    for (int k = 0; k < n; k++) src_q[i].push_back(first + 8'(k));
  endtask

  task automatic clear_src();
    for (int i = 0; i < 4; i++) src_q[i].delete();
  endtask

  // One clock cycle: drive at posedge+1, sample mid-cycle, update models, advance.
  task automatic cyc(input logic r, input logic [3:0] en, input logic wf);
    rst = r;
    bus.wfull = wf;
    for (int i = 0; i < 4; i++) begin
      bus.req[i] = en[i] && (src_q[i].size() > 0);
      bus.req_data[i*8 +: 8] = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
    end
    #4;
    s_gnt   = bus.gnt;
    s_ack   = bus.ack;
    s_winc  = bus.winc;
    s_wdata = bus.wdata;
    s_busy  = bus.busy;
    s_owner = bus.owner;
    if (s_winc && wf) viol++;
    if (s_winc) fifo_q.push_back(s_wdata);
    for (int i = 0; i < 4; i++) begin
      if (s_ack[i]) begin
        if (src_q[i].size() > 0) begin
          acked_q.push_back(src_q[i][0]);
          void'(src_q[i].pop_front());
        end else begin
          acked_q.push_back(8'hEE);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_vecs(input string tag);
    for (int r = 0; r < vecs.size(); r++) begin
      cyc(vecs[r].rst, vecs[r].en, vecs[r].wf);
      if (vecs[r].chk) begin
        chk($sformatf("%s r%0d gnt", tag, r), 32'(s_gnt), 32'(vecs[r].gnt));
        chk($sformatf("%s r%0d winc", tag, r), 32'(s_winc), 32'(vecs[r].winc));
        chk($sformatf("%s r%0d ack", tag, r), 32'(s_ack),
            32'(vecs[r].winc ? vecs[r].gnt : 4'b0000));
        chk($sformatf("%s r%0d busy", tag, r), 32'(s_busy), 32'(vecs[r].busy));
        chk($sformatf("%s r%0d owner", tag, r), 32'(s_owner), 32'(vecs[r].owner));
        if (vecs[r].winc)
          chk($sformatf("%s r%0d wdata", tag, r), 32'(s_wdata), 32'(vecs[r].wdata));
      end
    end
    vecs.delete();
  endtask

  initial begin
    logic [3:0] exp_g;
    logic [7:0] exp_d;
    int         o;
    int         mism;

    rst = 1'b1;
    bus.req = '0;
    bus.req_data = '0;
    bus.wfull = 1'b0;
    @(posedge clk);
    #1;

    // Test 1: single requester, 6 words, burst split 4 + 2
    load(1, 8'h10, 6);
    vecs.push_back(mk(1, 4'b0000, 0, 0, 4'b0000, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 1, 4'b0000, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 4'b0010, 0, 1, 4'b0000, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 4'b0010, 0, 1, 4'b0010, 1, 8'h10, 1, 1));
    vecs.push_back(mk(0, 4'b0010, 0, 1, 4'b0010, 1, 8'h11, 1, 1));
    vecs.push_back(mk(0, 4'b0010, 0, 1, 4'b0010, 1, 8'h12, 1, 1));
    vecs.push_back(mk(0, 4'b0010, 0, 1, 4'b0010, 1, 8'h13, 1, 1));
    vecs.push_back(mk(0, 4'b0010, 0, 1, 4'b0000, 0, 8'h00, 0, 1));
    vecs.push_back(mk(0, 4'b0010, 0, 1, 4'b0010, 1, 8'h14, 1, 1));
    vecs.push_back(mk(0, 4'b0010, 0, 1, 4'b0010, 1, 8'h15, 1, 1));
    vecs.push_back(mk(0, 4'b0010, 0, 1, 4'b0010, 0, 8'h00, 1, 1));
    vecs.push_back(mk(0, 4'b0010, 0, 1, 4'b0000, 0, 8'h00, 0, 1));
    run_vecs("t1");
    clear_src();

    // Test 2: all four requesting, order 0,1,2,3,0 with 4 words each
    for (int i = 0; i < 4; i++) load(i, 8'hA0 + 8'(i * 16), 8);
    cyc(1, 4'b0000, 0);
    for (int g = 0; g < 5; g++) begin
      o = g % 4;
      cyc(0, 4'b1111, 0);
      chk($sformatf("t2 g%0d bubble gnt", g), 32'(s_gnt), 32'h0);
      chk($sformatf("t2 g%0d bubble winc", g), 32'(s_winc), 32'h0);
      for (int k = 0; k < 4; k++) begin
        cyc(0, 4'b1111, 0);
        exp_g = 4'b0001 << o;
        exp_d = 8'hA0 + 8'(o * 16) + 8'((g / 4) * 4 + k);
        chk($sformatf("t2 g%0d k%0d gnt", g, k), 32'(s_gnt), 32'(exp_g));
        chk($sformatf("t2 g%0d k%0d winc", g, k), 32'(s_winc), 32'h1);
        chk($sformatf("t2 g%0d k%0d wdata", g, k), 32'(s_wdata), 32'(exp_d));
      end
    end
    cyc(0, 4'b0000, 0);
    chk("t2 end gnt", 32'(s_gnt), 32'h0);
    clear_src();

    // Test 3: owner 2 stalled by wfull for 3 cycles after 2 words
    load(2, 8'h30, 6);
    vecs.push_back(mk(0, 4'b0100, 0, 1, 4'b0000, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 4'b0100, 0, 1, 4'b0100, 1, 8'h30, 1, 2));
    vecs.push_back(mk(0, 4'b0100, 0, 1, 4'b0100, 1, 8'h31, 1, 2));
    vecs.push_back(mk(0, 4'b0100, 1, 1, 4'b0100, 0, 8'h00, 1, 2));
    vecs.push_back(mk(0, 4'b0100, 1, 1, 4'b0100, 0, 8'h00, 1, 2));
    vecs.push_back(mk(0, 4'b0100, 1, 1, 4'b0100, 0, 8'h00, 1, 2));
    vecs.push_back(mk(0, 4'b0100, 0, 1, 4'b0100, 1, 8'h32, 1, 2));
    vecs.push_back(mk(0, 4'b0100, 0, 1, 4'b0100, 1, 8'h33, 1, 2));
    vecs.push_back(mk(0, 4'b0000, 0, 1, 4'b0000, 0, 8'h00, 0, 2));
    run_vecs("t3");
    clear_src();

    // Test 4: owner 0 drops after 1 word; requester 3 wins over 0 next
    load(0, 8'h40, 4);
    load(3, 8'h50, 4);
    vecs.push_back(mk(0, 4'b0001, 0, 1, 4'b0000, 0, 8'h00, 0, 2));
    vecs.push_back(mk(0, 4'b1001, 0, 1, 4'b0001, 1, 8'h40, 1, 0));
    vecs.push_back(mk(0, 4'b1000, 0, 1, 4'b0001, 0, 8'h00, 1, 0));
    vecs.push_back(mk(0, 4'b1001, 0, 1, 4'b0000, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 4'b1001, 0, 1, 4'b1000, 1, 8'h50, 1, 3));
    vecs.push_back(mk(0, 4'b1001, 0, 1, 4'b1000, 1, 8'h51, 1, 3));
    vecs.push_back(mk(0, 4'b1001, 0, 1, 4'b1000, 1, 8'h52, 1, 3));
    vecs.push_back(mk(0, 4'b1001, 0, 1, 4'b1000, 1, 8'h53, 1, 3));
    vecs.push_back(mk(0, 4'b0000, 0, 1, 4'b0000, 0, 8'h00, 0, 3));
    run_vecs("t4");
    clear_src();

    // Test 5: reset mid-burst (owner 2, count 2), then last pointer restarts at 3
    load(2, 8'h60, 8);
    load(1, 8'h70, 8);
    vecs.push_back(mk(0, 4'b0100, 0, 1, 4'b0000, 0, 8'h00, 0, 3));
    vecs.push_back(mk(0, 4'b0100, 0, 1, 4'b0100, 1, 8'h60, 1, 2));
    vecs.push_back(mk(0, 4'b0100, 0, 1, 4'b0100, 1, 8'h61, 1, 2));
    vecs.push_back(mk(1, 4'b0100, 1, 1, 4'b0100, 0, 8'h00, 1, 2));
    vecs.push_back(mk(0, 4'b0110, 0, 1, 4'b0000, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 4'b0110, 0, 1, 4'b0010, 1, 8'h70, 1, 1));
    vecs.push_back(mk(0, 4'b0110, 0, 1, 4'b0010, 1, 8'h71, 1, 1));
    vecs.push_back(mk(0, 4'b0110, 0, 1, 4'b0010, 1, 8'h72, 1, 1));
    vecs.push_back(mk(0, 4'b0110, 0, 1, 4'b0010, 1, 8'h73, 1, 1));
    vecs.push_back(mk(0, 4'b0000, 0, 1, 4'b0000, 0, 8'h00, 0, 1));
    run_vecs("t5");
    clear_src();

    // Scoreboard: FIFO holds exactly the acked words, in ack order
    chk("sb fifo_count", 32'(fifo_q.size()), 32'd41);
    chk("sb ack_count", 32'(acked_q.size()), 32'(fifo_q.size()));
    mism = 0;
    for (int i = 0; i < fifo_q.size() && i < acked_q.size(); i++) begin
      if (fifo_q[i] !== acked_q[i]) mism++;
    end
    chk("sb order_mismatches", 32'(mism), 32'd0);
    chk("no_winc_while_full", 32'(viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
